// File: rtl/cpu_trace_buffer.sv
// Passive trace buffer: snapshots CPU state on every PC change into a
// show-ahead FIFO, counting captures dropped while the FIFO is full.
module cpu_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] f_in,
  input  logic [DW-1:0] mem_in,
  input  logic          zf_in,
  input  logic          of_in,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [DW-1:0] rd_pc,
  output logic [DW-1:0] rd_f,
  output logic [DW-1:0] rd_mem,
  output logic          rd_zf,
  output logic          rd_of,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  localparam int unsigned RW = 3*DW + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR = AW'(1);

  logic [RW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [7:0]     drop_cnt_q, drop_cnt_d;
  logic [DW-1:0]  pc_last_q, pc_last_d;
  logic           armed_q, armed_d;

  logic           full, empty, cap, pop, push, drop;
  logic [RW-1:0]  rec, head;

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    cap   = en & (~armed_q | (pc_in != pc_last_q));
    pop   = ~empty & rd_ready;
    push  = cap & (~full | pop);
    drop  = cap & full & ~pop;
    rec   = {pc_in, f_in, mem_in, zf_in, of_in};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    pc_last_d  = pc_last_q;
    armed_d    = armed_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
      pc_last_d  = '0;
      armed_d    = 1'b0;
    end else begin
      // A dropped capture still records its PC so it is not re-captured.
      if (cap) begin
        pc_last_d = pc_in;
        armed_d   = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + ONE_PTR;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE_PTR;
      unique case ({push, pop})
        2'b10:   count_d = count_q + ONE_CNT;
        2'b01:   count_d = count_q - ONE_CNT;
        default: count_d = count_q;
      endcase
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      pc_last_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      pc_last_q  <= pc_last_d;
      armed_q    <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= rec;
  end

  always_comb begin
    head     = empty ? '0 : mem_q[rd_ptr_q];
    rd_valid = ~empty;
    rd_pc    = head[RW-1 -: DW];
    rd_f     = head[2*DW+1 -: DW];
    rd_mem   = head[DW+1 -: DW];
    rd_zf    = head[1];
    rd_of    = head[0];
    count    = count_q;
    overflow = overflow_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: stimulus queues expected records,
// a forked monitor compares each record as the consumer accepts it.
module tb_cpu_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] f_in = '0;
  logic [31:0] mem_in = '0;
  logic        zf_in = 1'b0;
  logic        of_in = 1'b0;
  logic        rd_ready = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_pc, rd_f, rd_mem;
  logic        rd_zf, rd_of;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [97:0] exp_q[$];

  cpu_trace_buffer #(.DEPTH(16), .AW(4), .DW(32)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .pc_in(pc_in), .f_in(f_in), .mem_in(mem_in), .zf_in(zf_in), .of_in(of_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_pc(rd_pc), .rd_f(rd_f), .rd_mem(rd_mem), .rd_zf(rd_zf), .rd_of(rd_of),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [97:0] rec_of(input logic [31:0] p);
    return {p, ~p, p + 32'h1000, p[4], p[2]};
  endfunction

  task automatic chk(input string nm, input logic [97:0] act, input logic [97:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs, optionally queue the record it should push,
  // then return 1 time unit after the clock edge.
  task automatic drive(input logic e, input logic [31:0] p, input logic rdy,
                       input logic clr, input logic exp_push);
    en = e; pc_in = p; f_in = ~p; mem_in = p + 32'h1000;
    zf_in = p[4]; of_in = p[2]; rd_ready = rdy; clear = clr;
    if (exp_push) exp_q.push_back(rec_of(p));
    @(posedge clk);
    #1;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_record", {rd_pc, rd_f, rd_mem, rd_zf, rd_of}, '0);
          end else begin
            chk("record", {rd_pc, rd_f, rd_mem, rd_zf, rd_of}, exp_q.pop_front());
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rd_valid", 98'(rd_valid), 98'(0));
    chk("reset_count", 98'(count), 98'(0));
    chk("reset_rd_fields", {rd_pc, rd_f, rd_mem, rd_zf, rd_of}, '0);
    chk("reset_ovf_drop", 98'({overflow, drop_cnt}), 98'(0));

    // First capture at PC=0, then 4, 8; head visible right after first edge
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("latency_rd_valid", 98'(rd_valid), 98'(1));
    chk("latency_count", 98'(count), 98'(1));
    drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b1);
    chk("t1_count", 98'(count), 98'(3));
    chk("t1_head_f", 98'(rd_f), 98'(32'hFFFF_FFFF));
    repeat (3) drive(1'b0, 32'h8, 1'b1, 1'b0, 1'b0);
    chk("t1_drained", 98'(count), 98'(0));

    // Held PC and en toggling give a single record
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
    repeat (4) drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h10, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    chk("t2_one_record", 98'(count), 98'(1));
    drive(1'b1, 32'h14, 1'b1, 1'b0, 1'b1);
    chk("t2_pushpop_cnt1", 98'(count), 98'(1));
    drive(1'b0, 32'h14, 1'b1, 1'b0, 1'b0);
    chk("t2_empty", 98'({rd_valid, count}), 98'(0));

    // 18 distinct PCs into a 16-deep FIFO
    for (int i = 0; i < 18; i++)
      drive(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0, i < 16);
    chk("t3_count", 98'(count), 98'(16));
    chk("t3_overflow", 98'(overflow), 98'(1));
    chk("t3_drop_cnt", 98'(drop_cnt), 98'(2));
    drive(1'b1, 32'h100 + 32'(4*17), 1'b0, 1'b0, 1'b0);
    chk("t3_no_recapture", 98'(drop_cnt), 98'(2));
    repeat (16) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t3_drained", 98'({rd_valid, count}), 98'(0));
    chk("t3_sticky_ovf", 98'(overflow), 98'(1));

    // clear wins over simultaneous cap and pop at count=5
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'h400 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    chk("t5_count5", 98'(count), 98'(5));
    drive(1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
    exp_q.delete();
    chk("t5_cleared", 98'({rd_valid, count, overflow, drop_cnt}), 98'(0));
    drive(1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
    chk("t5_recapture_empty_pop", 98'(count), 98'(1));
    drive(1'b0, 32'h500, 1'b1, 1'b0, 1'b0);
    chk("t5_drained", 98'(count), 98'(0));

    // Full FIFO with a simultaneous pop accepts the new record
    for (int i = 0; i < 16; i++)
      drive(1'b1, 32'h200 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    chk("t4_full", 98'(count), 98'(16));
    drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b1);
    chk("t4_count", 98'(count), 98'(16));
    chk("t4_no_overflow", 98'({overflow, drop_cnt}), 98'(0));
    repeat (16) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("t4_drained", 98'({rd_valid, count}), 98'(0));

    // drop_cnt saturates at 255
    for (int i = 0; i < 16; i++)
      drive(1'b1, 32'h600 + 32'(4*i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++)
      drive(1'b1, 32'h1000 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    chk("sat_drop_cnt", 98'(drop_cnt), 98'(255));
    chk("sat_ovf_count", 98'({overflow, count}), 98'({1'b1, 5'd16}));
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    exp_q.delete();
    chk("sat_cleared", 98'({count, overflow, drop_cnt}), 98'(0));

    chk("scoreboard_empty", 98'(exp_q.size()), 98'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
